// File: rtl/board_io_conditioner.sv
// board_io_conditioner: synchronised, debounced switch/button inputs with sticky press flags and registered LEDs; define BOARD_IO_PWM_EN to enable global PWM dimming.
module board_io_conditioner #(
    parameter int N_SW            = 8,
    parameter int N_BTN           = 4,
    parameter int N_LED           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PWM_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SW-1:0]  sw_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_SW-1:0]  sw_db_o,
    output logic [N_BTN-1:0] btn_db_o,
    output logic [N_BTN-1:0] btn_evt_o,
    input  logic [N_BTN-1:0] evt_clr_i,
    input  logic [N_LED-1:0] led_val_i,
    input  logic [PWM_W-1:0] led_duty_i,
    output logic [N_LED-1:0] led_o
);
    localparam int N_IN = N_SW + N_BTN;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]  sync_q [SYNC_STAGES];
    logic [N_IN-1:0]  s, db_q, db_d;
    logic [CW-1:0]    cnt_q [N_IN];
    logic [CW-1:0]    cnt_d [N_IN];
    logic [N_BTN-1:0] btn_prev_q, evt_q, evt_d;
    logic [N_LED-1:0] led_q, led_d;

    assign s         = sync_q[SYNC_STAGES-1];
    assign sw_db_o   = db_q[N_SW-1:0];
    assign btn_db_o  = db_q[N_IN-1:N_SW];
    assign btn_evt_o = evt_q;
    assign led_o     = led_q;

    // A mismatch must persist for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = (s[i] == db_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CW'(1);
            db_d[i]  = (s[i] != db_q[i] && cnt_q[i] == LAST) ? s[i] : db_q[i];
        end
        evt_d = (btn_db_o & ~btn_prev_q) | (evt_q & ~evt_clr_i);
    end

`ifdef BOARD_IO_PWM_EN
    logic [PWM_W-1:0] pwm_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) pwm_q <= '0;
        else       pwm_q <= pwm_q + PWM_W'(1);
    end
    assign led_d = led_val_i & {N_LED{(pwm_q < led_duty_i) || (&led_duty_i)}};
`else
    logic unused_duty;
    assign unused_duty = ^led_duty_i;
    assign led_d = led_val_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
            db_q       <= '0;
            btn_prev_q <= '0;
            evt_q      <= '0;
            led_q      <= '0;
        end else begin
            sync_q[0] <= {btn_i, sw_i};
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            cnt_q      <= cnt_d;
            db_q       <= db_d;
            btn_prev_q <= btn_db_o;
            evt_q      <= evt_d;
            led_q      <= led_d;
        end
    end
endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner: directed vector bench for board_io_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PWM_W=4).
module tb_board_io_conditioner;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] sw_i = '0;
    logic [3:0] btn_i = '0;
    logic [7:0] sw_db_o;
    logic [3:0] btn_db_o;
    logic [3:0] btn_evt_o;
    logic [3:0] evt_clr_i = '0;
    logic [7:0] led_val_i = '0;
    logic [3:0] led_duty_i = '0;
    logic [7:0] led_o;
    int tests = 0;
    int fails = 0;
    int edges = 0;

    typedef struct {logic [7:0] sw; logic [7:0] exp_sw;} glitch_t;
    typedef struct {logic [7:0] val; logic [3:0] duty; logic [7:0] exp_led;} led_t;
    glitch_t gv [24];
    led_t    lv [6];

    board_io_conditioner #(
        .N_SW(8), .N_BTN(4), .N_LED(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PWM_W(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .sw_i(sw_i), .btn_i(btn_i),
        .sw_db_o(sw_db_o), .btn_db_o(btn_db_o), .btn_evt_o(btn_evt_o),
        .evt_clr_i(evt_clr_i), .led_val_i(led_val_i), .led_duty_i(led_duty_i), .led_o(led_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        gv = '{
            '{8'h08, 8'h00}, '{8'h08, 8'h00}, '{8'h08, 8'h00}, '{8'h00, 8'h00},
            '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00},
            '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00},
            '{8'h08, 8'h00}, '{8'h08, 8'h00}, '{8'h08, 8'h00}, '{8'h08, 8'h00},
            '{8'h00, 8'h00}, '{8'h00, 8'h08}, '{8'h00, 8'h08}, '{8'h00, 8'h08},
            '{8'h00, 8'h08}, '{8'h00, 8'h00}, '{8'h00, 8'h00}, '{8'h00, 8'h00}
        };
        lv = '{
            '{8'h00, 4'h0, 8'h00}, '{8'h3C, 4'h0, 8'h3C}, '{8'h3C, 4'hF, 8'h3C},
            '{8'h3C, 4'h5, 8'h3C}, '{8'hA5, 4'h7, 8'hA5}, '{8'hFF, 4'h0, 8'hFF}
        };

        // reset with every input high
        sw_i = 8'hFF; btn_i = 4'hF; evt_clr_i = 4'hF; led_val_i = 8'hFF; led_duty_i = 4'hF;
        rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_sw_db", sw_db_o, 8'h00);
        chk("rst_btn_db", {4'h0, btn_db_o}, 8'h00);
        chk("rst_evt", {4'h0, btn_evt_o}, 8'h00);
        chk("rst_led", led_o, 8'h00);
        rst_i = 1'b0; evt_clr_i = 4'h0; edges = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("rel_sw_db_%0d", k), sw_db_o, (k == 6) ? 8'hFF : 8'h00);
            chk($sformatf("rel_btn_db_%0d", k), {4'h0, btn_db_o}, (k == 6) ? 8'h0F : 8'h00);
            chk($sformatf("rel_evt_%0d", k), {4'h0, btn_evt_o}, 8'h00);
        end
        tick();
        chk("rel_evt_set", {4'h0, btn_evt_o}, 8'h0F);

        // return to an idle baseline
        sw_i = 8'h00; btn_i = 4'h0; evt_clr_i = 4'hF;
        repeat (8) tick();
        evt_clr_i = 4'h0;
        chk("idle_sw_db", sw_db_o, 8'h00);
        chk("idle_evt", {4'h0, btn_evt_o}, 8'h00);

        // glitch rejection: 3-cycle then 4-cycle pulse on sw[3]
        for (int i = 0; i < 24; i++) begin
            sw_i = gv[i].sw;
            tick();
            chk($sformatf("glitch_%0d", i), sw_db_o, gv[i].exp_sw);
        end

        // press event, clear, release, re-press
        btn_i = 4'h2;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("press_db_%0d", k), {4'h0, btn_db_o}, (k == 6) ? 8'h02 : 8'h00);
        end
        chk("press_evt_early", {4'h0, btn_evt_o}, 8'h00);
        tick();
        chk("press_evt", {4'h0, btn_evt_o}, 8'h02);
        evt_clr_i = 4'h2;
        tick();
        evt_clr_i = 4'h0;
        chk("press_clr", {4'h0, btn_evt_o}, 8'h00);
        btn_i = 4'h0;
        repeat (8) tick();
        chk("release_db", {4'h0, btn_db_o}, 8'h00);
        chk("release_evt", {4'h0, btn_evt_o}, 8'h00);
        btn_i = 4'h2;
        repeat (7) tick();
        chk("repress_evt", {4'h0, btn_evt_o}, 8'h02);
        btn_i = 4'h0; evt_clr_i = 4'hF;
        repeat (8) tick();
        evt_clr_i = 4'h0;
        chk("clear_all", {4'h0, btn_evt_o}, 8'h00);

        // set/clear collision: set wins, release does not clear
        evt_clr_i = 4'h4; btn_i = 4'h4;
        repeat (6) tick();
        chk("coll_db", {4'h0, btn_db_o}, 8'h04);
        chk("coll_evt_pre", {4'h0, btn_evt_o}, 8'h00);
        tick();
        evt_clr_i = 4'h0;
        chk("coll_evt_set", {4'h0, btn_evt_o}, 8'h04);
        btn_i = 4'h0;
        repeat (8) tick();
        chk("coll_rel_db", {4'h0, btn_db_o}, 8'h00);
        chk("coll_rel_evt", {4'h0, btn_evt_o}, 8'h04);
        evt_clr_i = 4'h4;
        tick();
        evt_clr_i = 4'h0;
        chk("coll_clr", {4'h0, btn_evt_o}, 8'h00);

`ifdef BOARD_IO_PWM_EN
        // LED output follows the free-running counter phase counted from reset release
        for (int d = 0; d < 3; d++) begin
            int on_cnt;
            logic [3:0] duty;
            duty = (d == 0) ? 4'd5 : (d == 1) ? 4'd0 : 4'd15;
            led_val_i = 8'hA5; led_duty_i = duty;
            on_cnt = 0;
            for (int k = 0; k < 16; k++) begin
                logic [7:0] exp_led;
                exp_led = ((((edges - 1) % 16) < int'(duty)) || duty == 4'hF) ? 8'hA5 : 8'h00;
                tick();
                exp_led = ((((edges - 1) % 16) < int'(duty)) || duty == 4'hF) ? 8'hA5 : 8'h00;
                if (led_o == 8'hA5) on_cnt++;
                chk($sformatf("pwm_d%0d_%0d", duty, k), led_o, exp_led);
            end
            chk($sformatf("pwm_on_cnt_d%0d", duty), 8'(on_cnt), (duty == 4'hF) ? 8'd16 : 8'(duty));
        end
`else
        led_val_i = 8'h00;
        tick();
        for (int i = 0; i < 6; i++) begin
            led_val_i = lv[i].val; led_duty_i = lv[i].duty;
            chk($sformatf("led_hold_%0d", i), led_o, (i == 0) ? 8'h00 : lv[i-1].exp_led);
            tick();
            chk($sformatf("led_%0d", i), led_o, lv[i].exp_led);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
